// File: rtl/arb_pkg.sv
// Shared arbiter types and helpers.
// Helpers work on a wide vector so any N up to MAXN can reuse them.
package arb_pkg;

   localparam int MAXN = 64;

   typedef logic [MAXN-1:0] vec_t;

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } state_t;

   function automatic int unsigned onehot_to_bin(input vec_t v);
      int unsigned r;
      r = 0;
      for (int i = 0; i < MAXN; i++) begin
         if (v[i]) r = r | i;
      end
      return r;
   endfunction

   // Rotate a one-hot left by one within the low n bits, wrapping n-1 -> 0.
   function automatic vec_t rotl1(input vec_t v, input int unsigned n);
      vec_t m;
      m = (vec_t'(1) << n) - vec_t'(1);
      return ((v << 1) | (v >> (n - 1))) & m;
   endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin pick: first request at or after ptr.
// Double-width masked priority encode handles the wrap.
module rr_pick #(
   parameter int N = 4
) (
   input  logic [N-1:0] req,
   input  logic [N-1:0] ptr,
   output logic [N-1:0] winner
);

   logic [2*N-1:0] dbl;
   logic [2*N-1:0] iso;

   // Low half keeps bits at/after ptr; high half is the wrapped copy.
   always_comb begin
      dbl    = {req, req & ~(ptr - N'(1))};
      iso    = dbl & (~dbl + (2*N)'(1));
      winner = iso[N-1:0] | iso[2*N-1:N];
   end

endmodule

// File: rtl/ring_rr_arbiter.sv
// Round-robin arbiter with rotating one-hot pointer,
// done/req-drop release and optional hold-time limit.
module ring_rr_arbiter
   import arb_pkg::*;
#(
   parameter int N        = 4,
   parameter int MAX_HOLD = 16,
   localparam int IDW     = (N > 1) ? $clog2(N) : 1,
   localparam int HCW     = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1
) (
   input  logic           clk,
   input  logic           rst,
   input  logic [N-1:0]   req,
   input  logic [N-1:0]   done,
   output logic [N-1:0]   gnt,
   output logic           gnt_valid,
   output logic [IDW-1:0] gnt_id,
   output logic           timeout
);

   localparam int            LIMI = (MAX_HOLD == 0) ? 0 : MAX_HOLD - 1;
   localparam logic [HCW-1:0] LIM = HCW'(LIMI);
   localparam bit            HAS_LIM = (MAX_HOLD != 0);

   state_t         state, state_n;
   logic [N-1:0]   ptr, ptr_n;
   logic [N-1:0]   win;
   logic [N-1:0]   gnt_n;
   logic [IDW-1:0] id_n;
   logic [HCW-1:0] hold_cnt, cnt_n;
   logic           to_n;
   logic           rel_done, rel_drop, rel_lim;

   rr_pick #(.N(N)) u_pick (
      .req    (req),
      .ptr    (ptr),
      .winner (win)
   );

   // Only the owner's done/req bits matter; gnt masks the rest.
   always_comb begin
      rel_done = |(done & gnt);
      rel_drop = ~|(req & gnt);
      rel_lim  = HAS_LIM && (hold_cnt == LIM);
   end

   // Next-state, pointer, hold counter and output decode.
   always_comb begin
      state_n = state;
      gnt_n   = gnt;
      id_n    = gnt_id;
      ptr_n   = ptr;
      cnt_n   = hold_cnt;
      to_n    = 1'b0;
      unique case (state)
         IDLE: begin
            if (|req) begin
               gnt_n   = win;
               id_n    = IDW'(onehot_to_bin(vec_t'(win)));
               cnt_n   = '0;
               state_n = GRANT;
            end
         end
         GRANT: begin
            if (rel_done || rel_drop || rel_lim) begin
               gnt_n   = '0;
               id_n    = '0;
               ptr_n   = N'(rotl1(vec_t'(gnt), N));
               cnt_n   = '0;
               to_n    = rel_lim && !rel_done && !rel_drop;
               state_n = IDLE;
            end else if (HAS_LIM && hold_cnt != LIM) begin
               cnt_n = hold_cnt + HCW'(1);
            end
         end
      endcase
   end

   // State and registered outputs; reset clears a grant instantly.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         ptr       <= N'(1);
         hold_cnt  <= '0;
         gnt       <= '0;
         gnt_valid <= 1'b0;
         gnt_id    <= '0;
         timeout   <= 1'b0;
      end else begin
         state     <= state_n;
         ptr       <= ptr_n;
         hold_cnt  <= cnt_n;
         gnt       <= gnt_n;
         gnt_valid <= |gnt_n;
         gnt_id    <= id_n;
         timeout   <= to_n;
      end
   end

endmodule

// File: tb/tb_ring_rr_arbiter.sv
// Directed bench for ring_rr_arbiter (N=4, MAX_HOLD=4 and 0).
// Expected values are hand-computed per step.
module tb_ring_rr_arbiter;

   logic       clk = 1'b0;
   logic       rst;
   logic [3:0] req, done, req0, done0;
   logic [3:0] gnt, g0;
   logic       gv, gv0, to, to0;
   logic [1:0] gid, gid0;

   int errs = 0;
   int checks = 0;
   int bad = 0;

   always #5 clk = ~clk;

   ring_rr_arbiter #(.N(4), .MAX_HOLD(4)) dut (
      .clk(clk), .rst(rst), .req(req), .done(done),
      .gnt(gnt), .gnt_valid(gv), .gnt_id(gid), .timeout(to)
   );

   ring_rr_arbiter #(.N(4), .MAX_HOLD(0)) dut0 (
      .clk(clk), .rst(rst), .req(req0), .done(done0),
      .gnt(g0), .gnt_valid(gv0), .gnt_id(gid0), .timeout(to0)
   );

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag,
                      input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   task automatic chkg(input string tag, input logic [3:0] e,
                       input logic [1:0] eid);
      chk({tag, ".gnt"}, 32'(gnt), 32'(e));
      chk({tag, ".id"}, 32'(gid), 32'(eid));
      chk({tag, ".vld"}, 32'(gv), 32'(|e));
   endtask

   initial begin
      rst = 1'b1; req = '0; done = '0; req0 = '0; done0 = '0;
      tick; tick;
      rst = 1'b0;
      tick;
      chkg("rst", 4'b0000, 2'd0);
      chk("rst.to", 32'(to), 32'd0);

      // 1: reset mid-grant
      req = 4'b0100;
      tick;
      chkg("t1.g2", 4'b0100, 2'd2);
      #2 rst = 1'b1;
      #1;
      chkg("t1.async", 4'b0000, 2'd0);
      @(posedge clk);
      #1 rst = 1'b0;
      req = 4'b1111;
      tick;
      chkg("t1.after", 4'b0001, 2'd0);

      // 2: rotation 0,1,2,3,0 with idle gaps
      for (int i = 1; i <= 4; i++) begin
         done = 4'(1 << ((i - 1) % 4));
         tick;
         chkg("t2.gap", 4'b0000, 2'd0);
         chk("t2.to", 32'(to), 32'd0);
         done = '0;
         tick;
         chkg("t2.rot", 4'(1 << (i % 4)), 2'(i % 4));
      end

      // 3: wrap and skip from ptr=1000
      req = 4'b0100;
      tick;
      chkg("t3.drop0", 4'b0000, 2'd0);
      tick;
      chkg("t3.g2", 4'b0100, 2'd2);
      req = 4'b0101; done = 4'b0100;
      tick;
      chkg("t3.rel2", 4'b0000, 2'd0);
      done = '0;
      tick;
      chkg("t3.wrap", 4'b0001, 2'd0);
      done = 4'b0001;
      tick;
      done = '0;
      tick;
      chkg("t3.skip", 4'b0100, 2'd2);
      req = '0;
      tick;
      chkg("t3.idle", 4'b0000, 2'd0);
      chk("t3.to", 32'(to), 32'd0);

      // 4: timeout after exactly 4 held cycles
      req = 4'b0010;
      tick;
      chkg("t4.c1", 4'b0010, 2'd1);
      for (int i = 2; i <= 4; i++) begin
         tick;
         chk("t4.hold", 32'(gnt), 32'h2);
         chk("t4.noto", 32'(to), 32'd0);
      end
      tick;
      chkg("t4.rel", 4'b0000, 2'd0);
      chk("t4.to", 32'(to), 32'd1);
      tick;
      chkg("t4.again", 4'b0010, 2'd1);
      chk("t4.to1", 32'(to), 32'd0);

      // 5: non-owner done ignored; done at limit is normal release
      done = 4'b1000;
      tick;
      chk("t5.nonown", 32'(gnt), 32'h2);
      done = '0;
      tick; tick;
      chk("t5.c4", 32'(gnt), 32'h2);
      done = 4'b0010;
      tick;
      chkg("t5.rel", 4'b0000, 2'd0);
      chk("t5.to", 32'(to), 32'd0);
      done = '0; req = '0;
      tick;

      // 6: MAX_HOLD=0 never times out; req drop releases
      req0 = 4'b0001;
      tick;
      chk("t6.g0", 32'(g0), 32'h1);
      for (int i = 0; i < 50; i++) begin
         tick;
         if (g0 !== 4'b0001 || to0 !== 1'b0) bad++;
      end
      chk("t6.held", 32'(bad), 32'd0);
      req0 = '0;
      tick;
      chk("t6.rel", 32'(g0), 32'h0);
      chk("t6.to", 32'(to0), 32'd0);
      chk("t6.id", 32'(gid0), 32'd0);
      req0 = 4'b1111;
      tick;
      chk("t6.ptr", 32'(g0), 32'h2);
      chk("t6.gid", 32'(gid0), 32'd1);
      chk("t6.vld", 32'(gv0), 32'd1);

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
